muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit.
- Consumes the two source operands read from the register file (RD1/RD2) plus the destination register index.
- Produces a one-cycle writeback strobe, result and destination index that drive the register file write port (WE3/WD3/AD3).
- Sits between operand read and writeback; the core stalls on busy.

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_unit_if.sv | 27 ++
 rtl/muldiv_unit_div_core.sv | 60 ++++++
 rtl/muldiv_unit.sv | 184 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings, constants and operand-sign helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned ITER_COUNT = 32;

    localparam logic [XLEN-1:0] DIV0_QUOT = '1;
    localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

    // Values match the RV32M funct3 field.
    typedef enum logic [2:0] {
        OpMul    = 3'b000,
        OpMulh   = 3'b001,
        OpMulhsu = 3'b010,
        OpMulhu  = 3'b011,
        OpDiv    = 3'b100,
        OpDivu   = 3'b101,
        OpRem    = 3'b110,
        OpRemu   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StDone
    } state_e;

    function automatic logic rs1_signed(op_e op);
        return op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
    endfunction

    function automatic logic rs2_signed(op_e op);
        return op inside {OpMul, OpMulh, OpDiv, OpRem};
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/writeback bundle between operand read, the muldiv unit and the register file write port.
interface muldiv_unit_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 5
);
    logic                     start;
    logic [2:0]               op;
    logic [DATA_WIDTH-1:0]    rs1_val;
    logic [DATA_WIDTH-1:0]    rs2_val;
    logic [ADDRESS_WIDTH-1:0] rd_in;
    logic                     flush;
    logic                     busy;
    logic                     done;
    logic [DATA_WIDTH-1:0]    result;
    logic [ADDRESS_WIDTH-1:0] rd_out;

    modport master (
        output start, op, rs1_val, rs2_val, rd_in, flush,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, op, rs1_val, rs2_val, rd_in, flush,
        output busy, done, result, rd_out
    );

endinterface

// File: rtl/muldiv_unit_div_core.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per step.
module div_core #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);
    localparam int unsigned W = DATA_WIDTH;

    logic [W-1:0] quo_q, quo_d;
    logic [W-1:0] rem_q, rem_d;
    logic [W-1:0] dvs_q, dvs_d;
    logic [W:0]   shifted;
    logic [W:0]   diff;

    always_comb begin
        shifted = {rem_q, quo_q[W-1]};
        // Partial remainder stays below the divisor, so diff[W] is a clean borrow flag.
        diff    = shifted - {1'b0, dvs_q};
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        if (start) begin
            quo_d = dividend;
            rem_d = '0;
            dvs_d = divisor;
        end else if (step) begin
            if (!diff[W]) begin
                rem_d = diff[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = shifted[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end

    // Post-step values, so the caller can latch the final answer on the last step edge.
    assign quotient  = quo_d;
    assign remainder = rem_d;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit driving the register file write port.
// Optional: define MULDIV_FAST_MUL_EN for a single-cycle multiplier on MUL-class ops.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 5
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    localparam int unsigned W    = DATA_WIDTH;
    localparam int unsigned CntW = $clog2(ITER_COUNT);

    state_e                   state_q, state_d;
    op_e                      op_q, op_d;
    logic                     neg_q, neg_d;
    logic [ADDRESS_WIDTH-1:0] rd_q, rd_d;
    logic [ADDRESS_WIDTH-1:0] rd_out_q, rd_out_d;
    logic [W-1:0]             mcand_q, mcand_d;
    logic [W-1:0]             result_q, result_d;
    logic [2*W-1:0]           prod_q, prod_d;
    logic [CntW-1:0]          cnt_q, cnt_d;

    logic [W:0]               acc_sum;
    logic [2*W-1:0]           prod_step;
    logic                     last_iter;

    op_e                      op_in;
    logic                     a_neg, b_neg, neg_in;
    logic                     div_zero, div_ovf;
    logic [W-1:0]             a_mag, b_mag, special_res;

    logic                     div_start, div_step;
    logic [W-1:0]             quotient, remainder;

    function automatic logic [W-1:0] mul_pick(op_e op, logic neg, logic [2*W-1:0] mag);
        logic [2*W-1:0] p;
        p = neg ? -mag : mag;
        return (op == OpMul) ? p[W-1:0] : p[2*W-1:W];
    endfunction

    function automatic logic [W-1:0] fix_sign(logic neg, logic [W-1:0] mag);
        return neg ? -mag : mag;
    endfunction

    // Request decode: magnitudes plus the single sign flag the chosen result needs.
    always_comb begin
        op_in    = op_e'(bus.op);
        a_neg    = rs1_signed(op_in) & bus.rs1_val[W-1];
        b_neg    = rs2_signed(op_in) & bus.rs2_val[W-1];
        a_mag    = a_neg ? -bus.rs1_val : bus.rs1_val;
        b_mag    = b_neg ? -bus.rs2_val : bus.rs2_val;
        neg_in   = (op_in == OpRem) ? a_neg : (a_neg ^ b_neg);
        div_zero = op_in[2] && (bus.rs2_val == '0);
        div_ovf  = ((op_in == OpDiv) || (op_in == OpRem)) &&
                   (bus.rs1_val == W'(INT_MIN)) && (bus.rs2_val == '1);
        if (div_zero) begin
            special_res = op_in[1] ? bus.rs1_val : W'(DIV0_QUOT);
        end else begin
            special_res = op_in[1] ? '0 : W'(INT_MIN);
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*W-1:0] fast_prod;
    assign fast_prod = {{W{1'b0}}, a_mag} * {{W{1'b0}}, b_mag};
`endif

    // Shift-add step: multiplier sits in the low half and shifts out as the product grows.
    assign acc_sum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
    assign prod_step = {acc_sum, prod_q[W-1:1]};
    assign last_iter = (cnt_q == CntW'(ITER_COUNT - 1));

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_d     = neg_q;
        rd_d      = rd_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        rd_out_d  = rd_out_q;
        div_start = 1'b0;
        div_step  = 1'b0;
        if (bus.flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    state_d = StIdle;
                    if (bus.start) begin
                        op_d    = op_in;
                        neg_d   = neg_in;
                        rd_d    = bus.rd_in;
                        mcand_d = a_mag;
                        prod_d  = {{W{1'b0}}, b_mag};
                        cnt_d   = '0;
                        if (div_zero || div_ovf) begin
                            state_d  = StDone;
                            result_d = special_res;
                            rd_out_d = bus.rd_in;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!op_in[2]) begin
                            state_d  = StDone;
                            result_d = mul_pick(op_in, neg_in, fast_prod);
                            rd_out_d = bus.rd_in;
`endif
                        end else if (op_in[2]) begin
                            state_d   = StDiv;
                            div_start = 1'b1;
                        end else begin
                            state_d = StMul;
                        end
                    end
                end
                StMul: begin
                    prod_d = prod_step;
                    cnt_d  = cnt_q + 1'b1;
                    if (last_iter) begin
                        state_d  = StDone;
                        result_d = mul_pick(op_q, neg_q, prod_step);
                        rd_out_d = rd_q;
                    end
                end
                StDiv: begin
                    div_step = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (last_iter) begin
                        state_d  = StDone;
                        result_d = fix_sign(neg_q, op_q[1] ? remainder : quotient);
                        rd_out_d = rd_q;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= OpMul;
            neg_q    <= 1'b0;
            rd_q     <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            rd_q     <= rd_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    div_core #(
        .DATA_WIDTH(W)
    ) u_div_core (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .step     (div_step),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quotient (quotient),
        .remainder(remainder)
    );

    assign bus.busy   = (state_q == StMul) || (state_q == StDiv);
    assign bus.done   = (state_q == StDone);
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M cases, flush/reset aborts, then random ops.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_unit_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) bus ();

    muldiv_unit #(
        .DATA_WIDTH   (32),
        .ADDRESS_WIDTH(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FastMul = 1'b1;
`else
    localparam bit FastMul = 1'b0;
`endif

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    int unsigned cycle    = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] last_res = '0;
    logic [4:0]  last_rd  = '0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural RV32M result from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa = $signed(a);
        longint      sbv = $signed(b);
        longint      ub = longint'({32'b0, b});
        logic [63:0] p;
        case (op)
            OpMul:    begin p = sa * sbv; return p[31:0];  end
            OpMulh:   begin p = sa * sbv; return p[63:32]; end
            OpMulhsu: begin p = sa * ub;  return p[63:32]; end
            OpMulhu:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            OpDiv: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sbv);
            end
            OpDivu:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OpRem: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sbv);
            end
            default:  return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycles from the start edge to the cycle where done is seen.
    function automatic int unsigned edges_to_done(input logic [2:0] op, input logic [31:0] a,
                                                  input logic [31:0] b);
        if (op[2] && b == 0) return 0;
        if ((op == OpDiv || op == OpRem) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        if (!op[2] && FastMul) return 0;
        return 32;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done with result 0x%08h rd %0d, required none",
                         bus.result, bus.rd_out);
            end else begin
                e = sb.pop_front();
                chk("result", bus.result, e.res);
                chk("rd_out", 32'(bus.rd_out), 32'(e.rd));
                chk("done_cycle", cycle, e.due);
                last_res = e.res;
                last_rd  = e.rd;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        int   n = 0;
        exp_t e;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_wait: busy still 1 after %0d cycles, required 0", n);
        end
        bus.op      = op;
        bus.rs1_val = a;
        bus.rs2_val = b;
        bus.rd_in   = rd;
        bus.start   = 1'b1;
        e.res = ref_model(op, a, b);
        e.rd  = rd;
        e.due = cycle + 1 + edges_to_done(op, a, b);
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cycles;
        bus.start   = 1'b0;
        bus.flush   = 1'b0;
        bus.op      = '0;
        bus.rs1_val = '0;
        bus.rs2_val = '0;
        bus.rd_in   = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_done", 32'(bus.done), 0);
        chk("reset_result", bus.result, 0);
        chk("reset_rd_out", 32'(bus.rd_out), 0);
        rst = 1'b0;
        @(negedge clk);

        issue(OpMul, 32'd7, 32'hFFFF_FFFD, 5'd5);
        busy_cycles = 0;
        while (bus.busy && busy_cycles < 100) begin
            busy_cycles++;
            @(negedge clk);
        end
        chk("mul_busy_cycles", busy_cycles, FastMul ? 0 : 32);

        issue(OpMulh,   32'h8000_0000, 32'h8000_0000, 5'd1);
        issue(OpMulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        issue(OpMulhsu, 32'hFFFF_FFFF, 32'd2,         5'd3);
        issue(OpDiv,    32'hFFFF_FFF9, 32'd2,         5'd4);
        issue(OpRem,    32'hFFFF_FFF9, 32'd2,         5'd6);
        issue(OpDivu,   32'd100,       32'd7,         5'd7);
        issue(OpRemu,   32'd100,       32'd7,         5'd8);
        issue(OpDiv,    32'd5,         32'd0,         5'd9);
        issue(OpRem,    32'd5,         32'd0,         5'd10);
        issue(OpDiv,    32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        issue(OpRem,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        issue(OpMul,    32'd6,         32'd7,         5'd0);

        // A start while busy must not disturb the op in flight.
        issue(OpDivu, 32'd100, 32'd7, 5'd3);
        repeat (5) @(negedge clk);
        bus.op      = OpRem;
        bus.rs1_val = 32'd123;
        bus.rs2_val = 32'd0;
        bus.rd_in   = 5'd9;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;

        // Flush mid-divide: no done, result/rd_out keep the last writeback.
        issue(OpDiv, 32'd1000, 32'd3, 5'd13);
        repeat (8) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        void'(sb.pop_back());
        chk("flush_busy", 32'(bus.busy), 0);
        chk("flush_result_held", bus.result, last_res);
        chk("flush_rd_held", 32'(bus.rd_out), 32'(last_rd));
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-divide clears outputs without waiting for an edge.
        issue(OpDiv, 32'd1000, 32'd3, 5'd14);
        repeat (8) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_result", bus.result, 0);
        chk("rst_rd_out", 32'(bus.rd_out), 0);
        void'(sb.pop_back());
        last_res = '0;
        last_rd  = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(OpRem, 32'hFFFF_FF9C, 32'd7, 5'd15);

        for (int i = 0; i < 50; i++) begin
            issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                  5'($urandom_range(0, 31)));
        end

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d results still pending, required 0", sb.size());
        end
        repeat (40) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
